// File: rtl/traffic_light_ctrl_param.sv
// ============================================================================
// Module   : traffic_light_ctrl_param
// Purpose  : Two-road (NS/EW) traffic-light controller with programmable phase
//            lengths, all-red clearance, latched pedestrian WALK and night flash.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl_param #(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 4,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    input  logic       flash_mode,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk_ns,
    output logic       ped_walk_ew,
    output logic [1:0] ped_pend,
    output logic [2:0] phase
);

    localparam logic [2:0] S_NS_G  = 3'd0;
    localparam logic [2:0] S_NS_Y  = 3'd1;
    localparam logic [2:0] S_AR1   = 3'd2;
    localparam logic [2:0] S_EW_G  = 3'd3;
    localparam logic [2:0] S_EW_Y  = 3'd4;
    localparam logic [2:0] S_AR2   = 3'd5;
    localparam logic [2:0] S_FLASH = 3'd6;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_DARK   = 3'b000;

    localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALLRED_TICKS - 1);
    // WALK covers the leading strobes of green, i.e. timer values above this.
    localparam int               WALK_THR = GREEN_TICKS - 1 - WALK_TICKS;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] load_val;
    logic             expire;
    logic             enter_ns_g;
    logic             enter_ew_g;
    logic             pend_ns;
    logic             pend_ew;
    logic             walk_ns_ok;
    logic             walk_ew_ok;
    logic             flash_on;
    logic             walk_window;

    assign expire     = tick_en && (timer == '0);
    assign enter_ns_g = (next_state == S_NS_G) && (state != S_NS_G);
    assign enter_ew_g = (next_state == S_EW_G) && (state != S_EW_G);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_AR2;
            timer      <= AR_LOAD;
            pend_ns    <= 1'b0;
            pend_ew    <= 1'b0;
            walk_ns_ok <= 1'b0;
            walk_ew_ok <= 1'b0;
            flash_on   <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                timer <= load_val;
            end else if (tick_en && (timer != '0)) begin
                timer <= timer - 1'b1;
            end

            if ((next_state == S_FLASH) && (state != S_FLASH)) begin
                flash_on <= 1'b1;
            end else if ((state == S_FLASH) && tick_en) begin
                flash_on <= ~flash_on;
            end

            // Green entry consumes the request, including one raised this cycle.
            pend_ns <= enter_ns_g ? 1'b0 : (pend_ns | ped_req_ns);
            pend_ew <= enter_ew_g ? 1'b0 : (pend_ew | ped_req_ew);
            if (enter_ns_g) begin
                walk_ns_ok <= pend_ns | ped_req_ns;
            end
            if (enter_ew_g) begin
                walk_ew_ok <= pend_ew | ped_req_ew;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_NS_G:  if (expire) next_state = S_NS_Y;
            S_NS_Y:  if (expire) next_state = S_AR1;
            S_AR1:   if (expire) next_state = flash_mode ? S_FLASH : S_EW_G;
            S_EW_G:  if (expire) next_state = S_EW_Y;
            S_EW_Y:  if (expire) next_state = S_AR2;
            S_AR2:   if (expire) next_state = flash_mode ? S_FLASH : S_NS_G;
            S_FLASH: if (tick_en && !flash_mode) next_state = S_AR2;
            default: next_state = S_AR2;
        endcase
    end

    always_comb begin
        load_val = AR_LOAD;
        case (next_state)
            S_NS_G, S_EW_G: load_val = G_LOAD;
            S_NS_Y, S_EW_Y: load_val = Y_LOAD;
            default:        load_val = AR_LOAD;
        endcase
    end

    assign walk_window = (WALK_THR < 0) || (int'(timer) > WALK_THR);

    always_comb begin
        ns_light    = L_RED;
        ew_light    = L_RED;
        ped_walk_ns = 1'b0;
        ped_walk_ew = 1'b0;
        case (state)
            S_NS_G: begin
                ns_light    = L_GREEN;
                ped_walk_ns = walk_ns_ok && walk_window;
            end
            S_NS_Y: ns_light = L_YELLOW;
            S_EW_G: begin
                ew_light    = L_GREEN;
                ped_walk_ew = walk_ew_ok && walk_window;
            end
            S_EW_Y: ew_light = L_YELLOW;
            S_FLASH: begin
                ns_light = flash_on ? L_YELLOW : L_DARK;
                ew_light = flash_on ? L_RED : L_DARK;
            end
            default: begin
                ns_light = L_RED;
                ew_light = L_RED;
            end
        endcase
        ped_pend = {pend_ew, pend_ns};
        phase    = state;
    end

endmodule

`default_nettype wire
